// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: exception causes,
// sequencer states, default handler vectors and the PC-source select for EPC.
package mips_pkg;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_OVF    = 2'b10;
  localparam logic [1:0] CAUSE_DIV0   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_LOAD = 2'd3;

  localparam logic [31:0] DEF_VEC_OPCODE   = 32'd253;
  localparam logic [31:0] DEF_VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0     = 32'd255;

  // PC-source mux select that picks EPC on return-from-exception
  localparam logic [1:0] PCSRC_EPC = 2'b11;

  function automatic logic [1:0] prio_cause(input logic opc, input logic ovf, input logic div0);
    if (opc)       return CAUSE_OPCODE;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exception_ctrl_latency_counter.sv
// Loadable down-counter with a zero flag; it parks at zero instead of wrapping.
module latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer: latches EPC/cause, fetches the handler vector byte from
// data memory and issues a one-cycle PC load, stalling main control via busy.
module exception_ctrl
  import mips_pkg::*;
#(
  parameter int          MEM_LATENCY  = 2,
  parameter logic [31:0] VEC_OPCODE   = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVERFLOW = DEF_VEC_OVERFLOW,
  parameter logic [31:0] VEC_DIV0     = DEF_VEC_DIV0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc,
  input  logic [7:0]  mem_data,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        pc_load,
  output logic [31:0] pc_next
);

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic       any_req;
  logic [1:0] req_cause;
  logic       cnt_zero;

  function automatic logic [31:0] vec_of(input logic [1:0] c);
    case (c)
      CAUSE_OPCODE: return VEC_OPCODE;
      CAUSE_OVF:    return VEC_OVERFLOW;
      CAUSE_DIV0:   return VEC_DIV0;
      default:      return 32'd0;
    endcase
  endfunction

  assign any_req   = exc_opcode | exc_ovf | exc_div0;
  assign req_cause = prio_cause(exc_opcode, exc_ovf, exc_div0);
  assign mem_rd    = (state == ST_READ);

  latency_counter #(
    .W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_READ),
    .load_val (CNT_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (cnt_zero)
  );

  // mem_addr is registered at the request edge so it is already valid in READ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      epc      <= '0;
      cause    <= CAUSE_NONE;
      mem_addr <= '0;
      busy     <= 1'b0;
      pc_load  <= 1'b0;
      pc_next  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            epc      <= pc - 32'd4;
            cause    <= req_cause;
            mem_addr <= vec_of(req_cause);
            busy     <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          if (cnt_zero) begin
            pc_next <= {24'b0, mem_data};
            pc_load <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pc_load <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequential exception sequencer for the multicycle MIPS datapath. It produces the EPC value that the PC-source selector reads on return-from-exception. On an exception it latches the faulting address and records the cause. It then fetches the handler's byte-wide vector from data memory and drives a one-cycle PC load with the zero-extended handler address. While it runs, the main control FSM is stalled through `busy`.

## Interface
- `MEM_LATENCY`, 2, cycles from the `mem_rd` cycle until `mem_data` is valid; must be ≥1.
- `VEC_OPCODE`, 32'd253, vector byte address for an invalid opcode.
- `VEC_OVERFLOW`, 32'd254, vector byte address for arithmetic overflow.
- `VEC_DIV0`, 32'd255, vector byte address for divide by zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `exc_opcode` in 1: invalid-opcode request, level sampled in IDLE.
- `exc_ovf` in 1: overflow request.
- `exc_div0` in 1: divide-by-zero request.
- `pc` in 32: current PC, already incremented by 4.
- `mem_data` in 8: memory read byte.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out 32: vector address.
- `epc` out 32: exception PC register.
- `cause` out 2: 00 none, 01 opcode, 10 overflow, 11 div0.
- `busy` out 1: sequencer active; the main control FSM holds while this is high.
- `pc_load` out 1: one-cycle PC write enable.
- `pc_next` out 32: handler address.

## Operation
- States: IDLE, READ, WAIT, LOAD.
- IDLE: if any request is high at the clock edge, latch the following, then go to READ:
  - `epc <= pc - 32'd4`, modulo 2^32. For example, `pc` = 0 gives `epc` = 0xFFFFFFFC.
  - `cause` by fixed priority: opcode > overflow > div0.
- If no request is high, stay in IDLE. `epc` and `cause` hold their values.
- READ: `mem_rd` = 1 for exactly this cycle, and `mem_addr` = the vector for `cause`. Load the wait counter with MEM_LATENCY−1, then go to WAIT.
- WAIT: `mem_addr` is held. The counter decrements each cycle. When the counter reaches 0, capture `mem_data` into the handler register at that edge and go to LOAD.
- LOAD: `pc_load` = 1 and `pc_next` = {24'b0, captured byte}. Return to IDLE.
- Requests arriving in READ, WAIT or LOAD are ignored and are not queued. A request still high on return to IDLE starts a new sequence.
- `epc` and `cause` persist after the sequence ends until the next exception or reset.
- `pc_next` holds its last value outside LOAD. It is only meaningful while `pc_load` = 1.

## Timing
- Reset (asynchronous, any state, including mid-sequence): go to IDLE with `epc` = 0, `cause` = 00, `mem_rd` = 0, `mem_addr` = 0, `busy` = 0, `pc_load` = 0, `pc_next` = 0, counter = 0. No partial PC load may occur.
- The request is sampled at edge E0. READ occupies cycle 1, WAIT occupies cycles 2..MEM_LATENCY+1, and LOAD occupies cycle MEM_LATENCY+2.
- With the default MEM_LATENCY = 2, `pc_load` is high in the 4th cycle after E0.
- `busy` is registered. It is high from READ through LOAD inclusive and low in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `exc_*` to any output.
- `mem_data` is sampled only at the final edge of WAIT.

## Structure
- Shared package `mips_pkg` holds:
  - the cause encodings: CAUSE_NONE, CAUSE_OPCODE, CAUSE_OVF, CAUSE_DIV0;
  - the state encoding;
  - the default vector addresses.
- The PC-source select value for EPC (2'b11) also lives in `mips_pkg` so that the control unit and this block agree on it.
- One natural sub-module is `latency_counter`: loadable down-counter with a zero flag, width $clog2(MEM_LATENCY)+1.
- The rest of the block is flat: one FSM plus its output registers.

## Test plan
- Reset mid-WAIT: assert `reset` during WAIT. All outputs must go to 0 immediately. `pc_load` must never pulse and the state must be IDLE.
- Overflow with `pc` = 0x0000_0040 and `mem_data` = 0x7C at the sample edge:
  - `epc` = 0x0000_003C and `cause` = 10;
  - `mem_rd` is high in cycle 1 with `mem_addr` = 254;
  - `pc_load` is high in cycle 4 with `pc_next` = 0x0000_007C;
  - `busy` is high for cycles 1–4.
- Simultaneous `exc_opcode`, `exc_ovf` and `exc_div0`: `cause` = 01 and `mem_addr` = 253. After completion with all requests low, exactly one `pc_load` pulse has occurred.
- Wrap-around: `exc_div0` with `pc` = 0. `epc` = 0xFFFFFFFC, `mem_addr` = 255, and `pc_next` = {24'b0, byte}.
- Request during busy: pulse `exc_ovf` in WAIT of an opcode sequence. `cause` stays 01 and only one sequence runs.
- Held request with MEM_LATENCY = 1: `exc_opcode` held high. Sequences repeat back-to-back with one IDLE cycle between them, and `pc_load` lands in cycle 3 after each sample edge.
